// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared definitions for the five-stage pipeline controller:
//                controller state encoding, base-ISA opcode constants and a
//                small state-classification helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Controller state; RUN/DRAIN/HALTED encodings are fixed so that other
    // blocks decoding the state see stable values.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } pipe_state_e;

    // Base-ISA major opcodes used by the decode and hazard logic.
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;

    // True in the states where the pipeline registers are allowed to move.
    function automatic logic pipe_moving(input pipe_state_e s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : sat_cnt
//  Description : Up-counter that increments by one when INC is high and
//                sticks at all-ones instead of wrapping.
//  Ports       : CLK   - clock, rising edge
//                RST_N - asynchronous active-low reset, clears the count
//                INC   - increment request for this cycle
//                CNT   - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             INC,
    output logic [WIDTH-1:0] CNT
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (INC && !(&cnt_q)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CNT = cnt_q;

endmodule : sat_cnt
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Stall/flush/halt controller for a five-stage pipeline.
//                Produces PC and inter-stage register enables/clears from the
//                hazard, branch and memory handshakes, tracks a valid bit per
//                stage, drains the pipe on a halt request and counts stalls.
//  Ports       : CLK, RST_N            - clock / async active-low reset
//                HAZ_STALL, HAZ_FLUSH  - load-use stall, JALR flush (decode)
//                BR_TAKEN              - branch taken, resolved in execute
//                IMEM_RDY              - fetch data valid this cycle
//                DMEM_REQ, DMEM_RDY    - memory-stage access pending / done
//                HALT_REQ, RESUME      - drain-and-stop / restart
//                PC_EN, *_EN, *_CLR    - register load enables / bubble loads
//                V_D..V_W              - per-stage valid bits
//                HALTED                - controller is halted
//                STALL_CNT             - saturating count of stalled RUN cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             HAZ_STALL,
    input  logic             HAZ_FLUSH,
    input  logic             BR_TAKEN,
    input  logic             IMEM_RDY,
    input  logic             DMEM_REQ,
    input  logic             DMEM_RDY,
    input  logic             HALT_REQ,
    input  logic             RESUME,
    output logic             PC_EN,
    output logic             FD_EN,
    output logic             DE_EN,
    output logic             EM_EN,
    output logic             MW_EN,
    output logic             FD_CLR,
    output logic             DE_CLR,
    output logic             EM_CLR,
    output logic             MW_CLR,
    output logic             V_D,
    output logic             V_E,
    output logic             V_M,
    output logic             V_W,
    output logic             HALTED,
    output logic [CNT_W-1:0] STALL_CNT
);

    pipe_state_e state_q, state_d;
    logic        v_d_q, v_e_q, v_m_q, v_w_q;
    logic        v_d_d, v_e_d, v_m_d, v_w_d;
    logic        w_dmem_wait;
    logic        w_stall_inc;

    // A memory access only blocks when a real instruction sits in M.
    assign w_dmem_wait = v_m_q & DMEM_REQ & ~DMEM_RDY;

    // ------------------------------------------------------------------
    // Enables and clears
    // ------------------------------------------------------------------
    always_comb begin
        PC_EN  = 1'b0;
        FD_EN  = 1'b0;
        DE_EN  = 1'b0;
        EM_EN  = 1'b0;
        MW_EN  = 1'b0;
        FD_CLR = 1'b0;
        DE_CLR = 1'b0;
        EM_CLR = 1'b0;
        MW_CLR = 1'b0;

        if (pipe_moving(state_q)) begin
            PC_EN = 1'b1;
            FD_EN = 1'b1;
            DE_EN = 1'b1;
            EM_EN = 1'b1;
            MW_EN = 1'b1;

            // Only the highest-priority active condition alters the default.
            if (w_dmem_wait) begin
                // Freeze everything upstream of M; W receives a bubble.
                PC_EN  = 1'b0;
                FD_EN  = 1'b0;
                DE_EN  = 1'b0;
                EM_EN  = 1'b0;
                MW_CLR = 1'b1;
            end else if (BR_TAKEN) begin
                FD_CLR = 1'b1;
                DE_CLR = 1'b1;
            end else if (HAZ_FLUSH) begin
                FD_CLR = 1'b1;
            end else if (HAZ_STALL) begin
                PC_EN  = 1'b0;
                FD_EN  = 1'b0;
                DE_CLR = 1'b1;
            end else if (!IMEM_RDY) begin
                PC_EN  = 1'b0;
                FD_CLR = 1'b1;
            end

            // While draining nothing new is fetched: whatever F/D loads is a
            // bubble, and the PC only moves to capture a redirect target.
            // A held decode register (stall or memory wait) is left intact.
            if (state_q == ST_DRAIN) begin
                if (FD_EN) begin
                    FD_CLR = 1'b1;
                end
                if (!BR_TAKEN && !HAZ_FLUSH) begin
                    PC_EN = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next valid bits: clear wins, enable shifts the upstream bit, else hold
    // ------------------------------------------------------------------
    always_comb begin
        v_d_d = v_d_q;
        v_e_d = v_e_q;
        v_m_d = v_m_q;
        v_w_d = v_w_q;

        if (FD_CLR)     v_d_d = 1'b0;
        else if (FD_EN) v_d_d = (state_q == ST_RUN);

        if (DE_CLR)     v_e_d = 1'b0;
        else if (DE_EN) v_e_d = v_d_q;

        if (EM_CLR)     v_m_d = 1'b0;
        else if (EM_EN) v_m_d = v_e_q;

        if (MW_CLR)     v_w_d = 1'b0;
        else if (MW_EN) v_w_d = v_m_q;
    end

    // ------------------------------------------------------------------
    // State transitions
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (HALT_REQ) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Judged on the post-edge valids so an empty pipe leaves
                // after a single drain cycle.
                if (!(v_d_d | v_e_d | v_m_d | v_w_d) && !w_dmem_wait) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (RESUME) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            v_d_q   <= 1'b0;
            v_e_q   <= 1'b0;
            v_m_q   <= 1'b0;
            v_w_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            v_d_q   <= v_d_d;
            v_e_q   <= v_e_d;
            v_m_q   <= v_m_d;
            v_w_q   <= v_w_d;
        end
    end

    assign V_D    = v_d_q;
    assign V_E    = v_e_q;
    assign V_M    = v_m_q;
    assign V_W    = v_w_q;
    assign HALTED = (state_q == ST_HALTED);

    // ------------------------------------------------------------------
    // Stall statistics: only RUN cycles where the PC failed to advance
    // ------------------------------------------------------------------
    assign w_stall_inc = (state_q == ST_RUN) && !PC_EN;

    sat_cnt #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .INC   (w_stall_inc),
        .CNT   (STALL_CNT)
    );

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Directed self-checking bench for pipe_ctrl. A second
//                instance with a 2-bit stall counter shares the stimulus and
//                is used for the counter saturation case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic HAZ_STALL = 1'b0, HAZ_FLUSH = 1'b0, BR_TAKEN = 1'b0, IMEM_RDY = 1'b0;
    logic DMEM_REQ = 1'b0, DMEM_RDY = 1'b0, HALT_REQ = 1'b0, RESUME = 1'b0;

    logic        PC_EN, FD_EN, DE_EN, EM_EN, MW_EN;
    logic        FD_CLR, DE_CLR, EM_CLR, MW_CLR;
    logic        V_D, V_E, V_M, V_W, HALTED;
    logic [15:0] STALL_CNT;

    logic        b_PC_EN, b_FD_EN, b_DE_EN, b_EM_EN, b_MW_EN;
    logic        b_FD_CLR, b_DE_CLR, b_EM_CLR, b_MW_CLR;
    logic        b_V_D, b_V_E, b_V_M, b_V_W, b_HALTED;
    logic [1:0]  b_STALL_CNT;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    pipe_ctrl #(.CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .HAZ_STALL(HAZ_STALL), .HAZ_FLUSH(HAZ_FLUSH),
        .BR_TAKEN(BR_TAKEN), .IMEM_RDY(IMEM_RDY), .DMEM_REQ(DMEM_REQ),
        .DMEM_RDY(DMEM_RDY), .HALT_REQ(HALT_REQ), .RESUME(RESUME),
        .PC_EN(PC_EN), .FD_EN(FD_EN), .DE_EN(DE_EN), .EM_EN(EM_EN), .MW_EN(MW_EN),
        .FD_CLR(FD_CLR), .DE_CLR(DE_CLR), .EM_CLR(EM_CLR), .MW_CLR(MW_CLR),
        .V_D(V_D), .V_E(V_E), .V_M(V_M), .V_W(V_W), .HALTED(HALTED),
        .STALL_CNT(STALL_CNT)
    );

    pipe_ctrl #(.CNT_W(2)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .HAZ_STALL(HAZ_STALL), .HAZ_FLUSH(HAZ_FLUSH),
        .BR_TAKEN(BR_TAKEN), .IMEM_RDY(IMEM_RDY), .DMEM_REQ(DMEM_REQ),
        .DMEM_RDY(DMEM_RDY), .HALT_REQ(HALT_REQ), .RESUME(RESUME),
        .PC_EN(b_PC_EN), .FD_EN(b_FD_EN), .DE_EN(b_DE_EN), .EM_EN(b_EM_EN),
        .MW_EN(b_MW_EN), .FD_CLR(b_FD_CLR), .DE_CLR(b_DE_CLR), .EM_CLR(b_EM_CLR),
        .MW_CLR(b_MW_CLR), .V_D(b_V_D), .V_E(b_V_E), .V_M(b_V_M), .V_W(b_V_W),
        .HALTED(b_HALTED), .STALL_CNT(b_STALL_CNT)
    );

    // Grouped views: {PC,FD,DE,EM,MW} enables, {FD,DE,EM,MW} clears, {D,E,M,W} valids
    wire [4:0] en  = {PC_EN, FD_EN, DE_EN, EM_EN, MW_EN};
    wire [3:0] clr = {FD_CLR, DE_CLR, EM_CLR, MW_CLR};
    wire [3:0] vld = {V_D, V_E, V_M, V_W};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    logic [3:0] fill_seq  [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    logic [3:0] drain_seq [4] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};
    logic [3:0] br_refill [4] = '{4'b1001, 4'b1100, 4'b1110, 4'b1111};

    initial begin
        // ---------------- reset ----------------
        repeat (2) @(posedge CLK);
        #3;
        chk("rst_en",     en,        5'b00000);
        chk("rst_clr",    clr,       4'b0000);
        chk("rst_v",      vld,       4'b0000);
        chk("rst_halted", HALTED,    1'b0);
        chk("rst_cnt",    STALL_CNT, 16'd0);

        @(posedge CLK);
        #1;
        RST_N    = 1'b1;
        IMEM_RDY = 1'b1;
        settle();
        chk("idle_en", en,  5'b00000);
        chk("idle_v",  vld, 4'b0000);

        // ---------------- fill ----------------
        tick(); settle();
        chk("run_en",  en,  5'b11111);
        chk("run_clr", clr, 4'b0000);
        chk("run_v0",  vld, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            tick(); settle();
            chk("fill_v", vld, fill_seq[k]);
        end
        chk("fill_cnt", STALL_CNT, 16'd0);

        // ---------------- load-use stall ----------------
        HAZ_STALL = 1'b1;
        settle();
        chk("stall_en",  en,  5'b00111);
        chk("stall_clr", clr, 4'b0100);
        tick();
        HAZ_STALL = 1'b0;
        settle();
        chk("stall_v",   vld,       4'b1011);
        chk("stall_cnt", STALL_CNT, 16'd1);
        repeat (3) tick();
        settle();
        chk("refill1_v", vld, 4'b1111);

        // ---------------- priority: branch > flush > stall ----------------
        BR_TAKEN = 1'b1; HAZ_FLUSH = 1'b1; HAZ_STALL = 1'b1;
        settle();
        chk("br_pri_en",  en,  5'b11111);
        chk("br_pri_clr", clr, 4'b1100);
        tick();
        BR_TAKEN = 1'b0; HAZ_STALL = 1'b0;
        settle();
        chk("br_v",       vld, 4'b0011);
        chk("flush_en",   en,  5'b11111);
        chk("flush_clr",  clr, 4'b1000);
        tick();
        HAZ_FLUSH = 1'b0; HAZ_STALL = 1'b1; IMEM_RDY = 1'b0;
        settle();
        chk("flush_v",    vld, 4'b0001);
        chk("st_pri_en",  en,  5'b00111);
        chk("st_pri_clr", clr, 4'b0100);
        tick();
        HAZ_STALL = 1'b0;
        settle();
        chk("imem_v",   vld,       4'b0000);
        chk("imem_en",  en,        5'b01111);
        chk("imem_clr", clr,       4'b1000);
        chk("imem_cnt", STALL_CNT, 16'd2);
        tick();
        IMEM_RDY = 1'b1;
        settle();
        chk("imem_cnt2", STALL_CNT, 16'd3);
        repeat (4) tick();
        settle();
        chk("refill2_v", vld, 4'b1111);

        // ---------------- memory wait over a taken branch ----------------
        DMEM_REQ = 1'b1; DMEM_RDY = 1'b0; BR_TAKEN = 1'b1;
        settle();
        chk("dm_en",  en,  5'b00001);
        chk("dm_clr", clr, 4'b0001);
        tick(); settle();
        chk("dm_v",   vld, 4'b1110);
        chk("dm_en2", en,  5'b00001);
        tick(); settle();
        chk("dm_en3", en,  5'b00001);
        tick();
        DMEM_RDY = 1'b1;
        settle();
        chk("dm_rel_v",   vld,       4'b1110);
        chk("dm_rel_en",  en,        5'b11111);
        chk("dm_rel_clr", clr,       4'b1100);
        chk("dm_cnt",     STALL_CNT, 16'd6);
        tick();
        DMEM_REQ = 1'b0; DMEM_RDY = 1'b0; BR_TAKEN = 1'b0;
        settle();
        chk("dm_sq_v", vld, 4'b0011);
        for (int k = 0; k < 4; k++) begin
            tick(); settle();
            chk("refill3_v", vld, br_refill[k]);
        end

        // ---------------- halt / drain / resume ----------------
        HALT_REQ = 1'b1;
        settle();
        chk("halt_req_en", en, 5'b11111);
        tick();
        HALT_REQ = 1'b0;
        settle();
        chk("drain_en",  en,  5'b01111);
        chk("drain_clr", clr, 4'b1000);
        for (int k = 0; k < 4; k++) begin
            chk("drain_v",      vld,    drain_seq[k]);
            chk("drain_halted", HALTED, 1'b0);
            tick(); settle();
        end
        chk("halted",      HALTED,    1'b1);
        chk("halted_v",    vld,       4'b0000);
        chk("halted_en",   en,        5'b00000);
        chk("halted_clr",  clr,       4'b0000);
        chk("halted_cnt",  STALL_CNT, 16'd6);
        HALT_REQ = 1'b1;
        tick();
        HALT_REQ = 1'b0;
        settle();
        chk("halted_hold", HALTED, 1'b1);
        RESUME = 1'b1;
        tick();
        RESUME = 1'b0;
        settle();
        chk("resume_halted", HALTED, 1'b0);
        chk("resume_en",     en,     5'b11111);
        chk("resume_v",      vld,    4'b0000);
        tick(); settle();
        chk("resume_vd", vld, 4'b1000);

        // ---------------- reset mid-stall, then counter saturation ----------------
        HAZ_STALL = 1'b1;
        settle();
        RST_N = 1'b0;
        #1;
        chk("async_rst_en",  en,          5'b00000);
        chk("async_rst_v",   vld,         4'b0000);
        chk("async_rst_cnt", STALL_CNT,   16'd0);
        chk("async_rst_c2",  b_STALL_CNT, 2'd0);
        @(posedge CLK);
        #1;
        RST_N     = 1'b1;
        HAZ_STALL = 1'b0;
        IMEM_RDY  = 1'b0;
        settle();
        chk("post_rst_idle", en, 5'b00000);
        tick();
        for (int k = 1; k <= 5; k++) begin
            tick(); settle();
            chk("sat_cnt2", b_STALL_CNT, (k > 3) ? 32'd3 : 32'(k));
        end
        chk("sat_cnt16", STALL_CNT, 16'd5);
        tick(); settle();
        chk("sat_hold", b_STALL_CNT, 2'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_pipe_ctrl
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-002 CLK  input  1  pipeline clock; all state changes on the rising edge.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 HAZ_STALL  input  1  load-use stall request from the hazard unit (decode stage).
REQ-005 HAZ_FLUSH  input  1  JALR flush request from the hazard unit (decode stage).
REQ-006 BR_TAKEN  input  1  branch resolved taken in execute.
REQ-007 IMEM_RDY  input  1  instruction memory returned a valid fetch this cycle.
REQ-008 DMEM_REQ / DMEM_RDY  input  1 each  memory-stage access pending / access completes this cycle.
REQ-009 HALT_REQ / RESUME  input  1 each  drain-and-stop request / restart from halted.
REQ-010 PC_EN  output  1  PC register load enable.
REQ-011 FD_EN, DE_EN, EM_EN, MW_EN  output  1 each  inter-stage pipeline register load enables.
REQ-012 FD_CLR, DE_CLR, EM_CLR, MW_CLR  output  1 each  load a NOP bubble into that register; CLR=1 implies EN=1.
REQ-013 V_D, V_E, V_M, V_W  output  1 each  registered valid bit of each stage's instruction.
REQ-014 HALTED  output  1  high while in HALTED state.
REQ-015 STALL_CNT  output  CNT_W  saturating count of RUN cycles with PC_EN=0.

Function
REQ-016 FSM states IDLE, RUN, DRAIN, HALTED; enable/clear outputs are combinational from state and inputs; V_* and state are registered.
REQ-017 IDLE: all EN/CLR 0; unconditional transition to RUN next cycle.
REQ-018 RUN default (no condition active): every EN=1, every CLR=0.
REQ-019 Conditions apply with strict priority DMEM wait > BR_TAKEN > HAZ_FLUSH > HAZ_STALL > IMEM wait; only the highest active condition modifies the default.
REQ-020 DMEM wait (V_M & DMEM_REQ & !DMEM_RDY): PC_EN=FD_EN=DE_EN=EM_EN=0, MW_EN=MW_CLR=1.
REQ-021 BR_TAKEN: PC_EN=1, FD_CLR=DE_CLR=1 (squash D and E), EM/MW normal.
REQ-022 HAZ_FLUSH: PC_EN=1, FD_CLR=1, rest normal.
REQ-023 HAZ_STALL: PC_EN=0, FD_EN=0 (decode holds), DE_CLR=1 (bubble into E), EM/MW normal.
REQ-024 IMEM wait (!IMEM_RDY): PC_EN=0, FD_CLR=1, rest normal.
REQ-025 Valid update per register: CLR -> 0; EN & !CLR -> upstream valid (V_D takes 1 in RUN, 0 in DRAIN); !EN -> hold.
REQ-026 RUN -> DRAIN when HALT_REQ=1 at the clock edge; the cycle's enables still follow REQ-019.
REQ-027 DRAIN: FD_CLR=1 and PC_EN=0 unless BR_TAKEN or HAZ_FLUSH (then PC_EN=1 to capture target); other rules per REQ-019.
REQ-028 DRAIN -> HALTED when V_D..V_W all 0 and no DMEM wait; a pipeline already empty drains in one cycle.
REQ-029 HALTED: all EN/CLR 0, HALTED=1; RESUME -> RUN next cycle; HALT_REQ ignored in HALTED.
REQ-030 STALL_CNT increments by 1 per RUN cycle with PC_EN=0, saturates at all-ones, never wraps.

Reset
REQ-031 RST_N low asynchronously forces state IDLE, V_*=0, HALTED=0, STALL_CNT=0; all EN/CLR outputs 0 while reset is low.
REQ-032 Reset asserted mid-DRAIN or mid-stall discards all pending conditions; first post-reset cycle is IDLE.

Structure
REQ-033 State enum and the RUN/DRAIN/HALTED encodings live in shared package pipe_ctrl_pkg with the existing opcode definitions.
REQ-034 STALL_CNT is implemented by one sub-module sat_cnt (parameter WIDTH, inputs CLK, RST_N, INC).

Verification
REQ-035 Reset release, IMEM_RDY=1 for 4 cycles -> IDLE 1 cycle, then V_D,V_E,V_M,V_W rise on successive cycles.
REQ-036 HAZ_STALL one cycle in RUN -> PC_EN=0, FD_EN=0, DE_CLR=1; next cycle V_E=0, V_D held 1; STALL_CNT=1.
REQ-037 BR_TAKEN and HAZ_FLUSH and HAZ_STALL same cycle -> BR_TAKEN wins: PC_EN=1, FD_CLR=DE_CLR=1.
REQ-038 DMEM_REQ with DMEM_RDY low 3 cycles while BR_TAKEN=1 -> 3 frozen cycles, MW_CLR=1, V_W=0; branch squash applies on 4th cycle.
REQ-039 HALT_REQ with full pipeline -> DRAIN 4 cycles, HALTED=1 on 5th; RESUME -> RUN next cycle, V_D=1 one cycle later.
REQ-040 CNT_W=2, 5 IMEM-wait cycles -> STALL_CNT reaches 3 and holds.
